// File: rtl/ripple_count_capture_pkg.sv
// rtl/ripple_count_capture_pkg.sv - shared state encoding and default widths for the ripple counter capture block
package ripple_count_capture_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int DEF_CNT_W         = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_WRAP_W        = 8;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - per-bit multi-flop synchronizer; the first flop sees the raw asynchronous input
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - synchronizes a ripple counter, filters transients, commits settled counts and tracks wraps
module ripple_count_capture
  import ripple_count_capture_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WRAP_W        = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              clr,
  output logic [CNT_W-1:0]  stable_cnt,
  output logic              cnt_valid,
  output logic              wrap_pulse,
  output logic              skip_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int CTR_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] s;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             first_q;
  logic             commit;
  logic             is_wrap;
  logic [CNT_W-1:0] expected_next;

  sync_chain #(
    .WIDTH  (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STABLE;
      prev_q  <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ctr_q   <= ctr_d;
    end
  end

  // A run of SETTLE_CYCLES identical samples either commits or, if it matches the held value, abandons the glitch.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ctr_d   = ctr_q;
    commit  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != stable_cnt) begin
          state_d = ST_SETTLE;
          prev_d  = s;
          ctr_d   = CTR_ONE;
        end
      end
      ST_SETTLE: begin
        if (s != prev_q) begin
          prev_d = s;
          ctr_d  = CTR_ONE;
        end else if (ctr_q < CTR_LAST) begin
          ctr_d = ctr_q + CTR_ONE;
        end else begin
          state_d = ST_STABLE;
          commit  = (s != stable_cnt);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign expected_next = stable_cnt + CNT_W'(1);
  assign is_wrap       = commit && (s < stable_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
      cnt_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      skip_pulse <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      cnt_valid  <= commit;
      wrap_pulse <= is_wrap;
      skip_pulse <= commit && !first_q && (s != expected_next);
      if (commit) begin
        stable_cnt <= s;
        first_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wrap_count <= '0;
    end else if (is_wrap && (wrap_count != {WRAP_W{1'b1}})) begin
      wrap_count <= wrap_count + WRAP_W'(1);
    end
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb/tb_ripple_count_capture.sv - self-checking bench: vector table, corner sequences, randomized run against a window model
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] cnt_in;

  logic [3:0] stable_a, stable_b;
  logic       valid_a, valid_b, wrap_a, wrap_b, skip_a, skip_b;
  logic [7:0] wc_a;
  logic [1:0] wc_b;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_skip   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ripple_count_capture dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .stable_cnt (stable_a),
    .cnt_valid  (valid_a),
    .wrap_pulse (wrap_a),
    .skip_pulse (skip_a),
    .wrap_count (wc_a)
  );

  ripple_count_capture #(.WRAP_W(2)) dut_w2 (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .stable_cnt (stable_b),
    .cnt_valid  (valid_b),
    .wrap_pulse (wrap_b),
    .skip_pulse (skip_b),
    .wrap_count (wc_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a value commits once the last three synchronized samples agree and differ from the held value.
  logic [3:0] m_d1, m_d2, m_stable, m_s, m_next;
  logic [3:0] m_w [3];
  bit         m_valid, m_wrap, m_skip, m_first;
  int         m_wc, m_wc2;

  task automatic model_step();
    if (reset) begin
      m_d1 = 0; m_d2 = 0; m_stable = 0;
      m_w[0] = 0; m_w[1] = 0; m_w[2] = 0;
      m_valid = 0; m_wrap = 0; m_skip = 0; m_first = 1;
      m_wc = 0; m_wc2 = 0;
    end else begin
      m_s  = m_d2;
      m_d2 = m_d1;
      m_d1 = cnt_in;
      m_w[2] = m_w[1]; m_w[1] = m_w[0]; m_w[0] = m_s;
      m_valid = 0; m_wrap = 0; m_skip = 0;
      if (m_w[0] == m_w[1] && m_w[1] == m_w[2] && m_w[0] != m_stable) begin
        m_next   = m_stable + 4'd1;
        m_valid  = 1;
        m_wrap   = (m_w[0] < m_stable);
        m_skip   = !m_first && (m_w[0] != m_next);
        m_stable = m_w[0];
        m_first  = 0;
      end
      if (clr) begin
        m_wc = 0; m_wc2 = 0;
      end else if (m_wrap) begin
        if (m_wc < 255) m_wc++;
        if (m_wc2 < 3) m_wc2++;
      end
    end
  endtask

  initial begin
    m_wc = 0; m_wc2 = 0; m_first = 1;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (valid_a === 1'b1) n_valid++;
        if (skip_a === 1'b1) n_skip++;
        check("model_cycle",
              {8'd0, stable_a, valid_a, wrap_a, skip_a, wc_a, stable_b, valid_b, wrap_b, skip_b, wc_b},
              {8'd0, m_stable, m_valid, m_wrap, m_skip, 8'(m_wc), m_stable, m_valid, m_wrap, m_skip, 2'(m_wc2)});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] val;
    int         cycles;
    logic       exp_valid;
    logic       exp_wrap;
    logic       exp_skip;
    logic [3:0] exp_stable;
  } vec_t;

  vec_t tbl [16];
  int   v0, s0;
  bit   seen;

  initial begin
    for (int i = 0; i < 15; i++) tbl[i] = '{4'(i + 1), 10, 1'b1, 1'b0, 1'b0, 4'(i + 1)};
    tbl[15] = '{4'd0, 10, 1'b1, 1'b1, 1'b0, 4'd0};

    reset = 1'b1; clr = 1'b0; cnt_in = 4'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_stable", stable_a, 0);
    check("reset_valid", valid_a, 0);
    check("reset_wrap_count", wc_a, 0);
    reset = 1'b0;

    hold(20);
    check("idle_stable", stable_a, 0);
    check("idle_no_commit", n_valid, 0);
    check("idle_wrap_count", wc_a, 0);

    v0 = n_valid; s0 = n_skip;
    for (int i = 0; i < 16; i++) begin
      cnt_in = tbl[i].val;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check($sformatf("step%0d_valid", i), valid_a, tbl[i].exp_valid);
      check($sformatf("step%0d_wrap", i), wrap_a, tbl[i].exp_wrap);
      check($sformatf("step%0d_skip", i), skip_a, tbl[i].exp_skip);
      hold(tbl[i].cycles - 5);
      check($sformatf("step%0d_stable", i), stable_a, tbl[i].exp_stable);
    end
    check("steps_commits", n_valid - v0, 16);
    check("steps_skips", n_skip - s0, 0);
    check("steps_wrap_count", wc_a, 1);

    cnt_in = 4'd7;
    hold(12);
    v0 = n_valid; s0 = n_skip;
    cnt_in = 4'd6; hold(1);
    cnt_in = 4'd4; hold(1);
    cnt_in = 4'd0; hold(1);
    cnt_in = 4'd8;
    hold(12);
    check("burst_commits", n_valid - v0, 1);
    check("burst_stable", stable_a, 8);
    check("burst_skip", n_skip - s0, 0);

    cnt_in = 4'd3;
    hold(12);
    v0 = n_valid;
    cnt_in = 4'd2; hold(2);
    cnt_in = 4'd3;
    hold(15);
    check("glitch_commits", n_valid - v0, 0);
    check("glitch_stable", stable_a, 3);

    for (int i = 0; i < 6; i++) begin
      cnt_in = 4'hF; hold(10);
      cnt_in = 4'h0; hold(10);
    end
    check("wrap_count_w8", wc_a, 8);
    check("wrap_count_w2_sat", wc_b, 3);

    cnt_in = 4'hF; hold(10);
    cnt_in = 4'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check("clr_wrap_pulse", wrap_a, 1);
    check("clr_wrap_count_w8", wc_a, 0);
    check("clr_wrap_count_w2", wc_b, 0);

    cnt_in = 4'd2; hold(10);
    cnt_in = 4'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_stable", stable_a, 0);
    check("midreset_valid", valid_a, 0);
    hold(1);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        seen = 1'b1;
        check("postreset_stable", stable_a, 5);
        check("postreset_skip", skip_a, 0);
        check("postreset_wrap", wrap_a, 0);
      end
    end
    check("postreset_commit_seen", seen, 1);

    for (int i = 0; i < 300; i++) begin
      cnt_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cnt_in + 4'd1;
      clr    = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 79) == 0);
      hold(1);
      clr   = 1'b0;
      reset = 1'b0;
      hold($urandom_range(0, 5));
    end
    hold(10);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
